// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage.
//   XLEN / INST_W     : address and instruction widths
//   RESET_PC_DEFAULT  : default boot address
//   fetch_state_e     : fetch controller states
//   fetch_entry_t     : one fetch-buffer entry {pc, inst}
package fetch_unit_pkg;

  localparam int XLEN   = 32;
  localparam int INST_W = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    S_BOOT  = 1'b0,
    S_FETCH = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_fifo.sv
// Small synchronous FIFO with registered storage and a combinational head.
// Used for the fetch buffer and for the outstanding-request pc-tag queue.
//   clk, reset   : clock, asynchronous active-low reset (control only)
//   push         : write push_data (ignored when full with no same-cycle pop)
//   pop          : drop the head entry (ignored when empty)
//   flush        : empty the FIFO; wins over push and pop
//   head         : current head entry, valid while count != 0
//   count        : current occupancy
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  input  logic                         flush,
  output logic [WIDTH-1:0]             head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  // Explicit wrap so non-power-of-two depths also work.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  // Storage carries no reset; the head is only meaningful while count != 0.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage feeding the decode controller.
// Owns the PC, issues in-order word reads to instruction memory, buffers the
// returned words with their PCs and hands them to decode. Redirects flush the
// buffer and mark every in-flight response as stale.
//   clk, reset                    : clock, asynchronous active-low reset
//   imem_req_valid/ready/addr     : read request channel (valid/ready)
//   imem_rsp_valid/data           : in-order read response (valid only)
//   inst_valid/ready, inst, inst_pc : decode handshake, buffer head
//   redirect, redirect_pc         : restart fetch at redirect_pc (word aligned)
//   flushing                      : stale responses still to be dropped
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int              DEPTH     = 2,
  parameter int              MAX_OUTST = 2
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [XLEN-1:0]   imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [XLEN-1:0]   inst_pc,
  input  logic              redirect,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              flushing
);

  localparam int OW = $clog2(MAX_OUTST+1);
  localparam int CW = $clog2(DEPTH+1);

  fetch_state_e    state_q;
  fetch_state_e    state_d;
  logic [XLEN-1:0] pc;
  logic [OW-1:0]   outst;
  logic [OW-1:0]   outst_next;
  logic [OW-1:0]   drop;
  logic [CW-1:0]   occ;
  logic [OW-1:0]   tag_count;
  logic [XLEN-1:0] tag_head;
  fetch_entry_t    buf_head;
  fetch_entry_t    buf_push_data;
  logic            req_fire;
  logic            rsp_fire;
  logic            buf_push;
  logic            buf_pop;
  logic            unused_rpc_bits;

  assign unused_rpc_bits = ^redirect_pc[1:0];

  // Next state and request valid. The occupancy term reserves one buffer
  // slot per live (non-stale) outstanding request, so a response always has
  // room and a raised request cannot be withdrawn except by redirect.
  always_comb begin
    state_d        = state_q;
    imem_req_valid = 1'b0;
    case (state_q)
      S_BOOT:  state_d = S_FETCH;
      S_FETCH: begin
        if (!redirect && (int'(outst) < MAX_OUTST) &&
            ((int'(occ) + int'(outst) - int'(drop)) < DEPTH))
          imem_req_valid = 1'b1;
      end
      default: state_d = S_BOOT;
    endcase
  end

  assign imem_req_addr = pc;
  assign req_fire      = imem_req_valid && imem_req_ready;
  assign rsp_fire      = imem_rsp_valid && (outst != '0);

  always_comb begin
    outst_next = outst;
    if (req_fire && !rsp_fire)      outst_next = outst + 1'b1;
    else if (!req_fire && rsp_fire) outst_next = outst - 1'b1;
  end

  // A response in a redirect cycle is already wrong-path, so it is not pushed.
  assign buf_push      = rsp_fire && (drop == '0) && !redirect;
  assign buf_pop       = inst_valid && inst_ready;
  assign buf_push_data = '{pc: tag_head, inst: imem_rsp_data};

  // ---- control state register ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_BOOT;
      pc      <= RESET_PC;
      outst   <= '0;
      drop    <= '0;
    end else begin
      state_q <= state_d;
      outst   <= outst_next;
      if (redirect) begin
        pc   <= {redirect_pc[XLEN-1:2], 2'b00};
        drop <= outst_next;
      end else begin
        if (req_fire) pc <= pc + 32'd4;
        if (rsp_fire && (drop != '0)) drop <= drop - 1'b1;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (MAX_OUTST),
    .WIDTH (XLEN)
  ) u_tag_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (req_fire),
    .push_data (pc),
    .pop       (rsp_fire),
    .flush     (1'b0),
    .head      (tag_head),
    .count     (tag_count)
  );

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_buf_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (buf_push),
    .push_data (buf_push_data),
    .pop       (buf_pop),
    .flush     (redirect),
    .head      (buf_head),
    .count     (occ)
  );

  assign inst_valid = (occ != '0);
  assign inst       = inst_valid ? buf_head.inst : '0;
  assign inst_pc    = inst_valid ? buf_head.pc   : '0;
  assign flushing   = (drop != '0);

  a_rsp_with_outst: assert property (@(posedge clk) disable iff (!reset)
    imem_rsp_valid |-> (outst != '0));

  a_tag_tracks_outst: assert property (@(posedge clk) disable iff (!reset)
    tag_count == outst);

endmodule
